// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter: instruction refill BIU (m0) and ITLB walker (m1)
// share one bus; round-robin on contention, no preemption, per-owner response timeout.
module wb_mem_arbiter #(
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic [31:0] m1_dat_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  input  logic [31:0] wb_dat_i,
  output logic [1:0]  gnt_o,
  output logic        to_err_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  localparam logic [7:0] TO_CNT = 8'(TO_CYCLES);

  state_e     state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic       own0, own1, own_stb, resp, to_match, to_hit;

  assign own0     = (state_q == OWN0);
  assign own1     = (state_q == OWN1);
  assign own_stb  = (own0 & m0_stb_i) | (own1 & m1_stb_i);
  assign resp     = wb_ack_i | wb_err_i | wb_rty_i;
  assign to_match = (own0 | own1) & (cnt_q == TO_CNT);
  // A real response in the match cycle wins over the synthetic error.
  assign to_hit   = to_match & own_stb & ~resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = '0;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_gnt_q ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_d = OWN0;
        else if (m1_cyc_i)        state_d = OWN1;
      end
      OWN0: if (!m0_cyc_i) state_d = m1_cyc_i ? OWN1 : IDLE;
      OWN1: if (!m1_cyc_i) state_d = m0_cyc_i ? OWN0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == OWN0 && state_q != OWN0) last_gnt_d = 1'b0;
    if (state_d == OWN1 && state_q != OWN1) last_gnt_d = 1'b1;
    if (!(state_d != state_q || resp || !own_stb || to_match))
      cnt_d = cnt_q + 8'd1;
  end

  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_sel_o = '0;
    wb_cti_o = '0;
    wb_bte_o = '0;
    if (own0) begin
      wb_cyc_o = m0_cyc_i;
      wb_stb_o = m0_stb_i & ~to_match;
      wb_we_o  = m0_we_i;
      wb_adr_o = m0_adr_i;
      wb_dat_o = m0_dat_i;
      wb_sel_o = m0_sel_i;
      wb_cti_o = m0_cti_i;
      wb_bte_o = m0_bte_i;
    end else if (own1) begin
      wb_cyc_o = m1_cyc_i;
      wb_stb_o = m1_stb_i & ~to_match;
      wb_we_o  = m1_we_i;
      wb_adr_o = m1_adr_i;
      wb_dat_o = m1_dat_i;
      wb_sel_o = m1_sel_i;
      wb_cti_o = m1_cti_i;
      wb_bte_o = m1_bte_i;
    end
  end

  assign m0_ack_o = wb_ack_i & own0 & m0_stb_i;
  assign m0_err_o = (wb_err_i | to_hit) & own0 & m0_stb_i;
  assign m0_rty_o = wb_rty_i & own0 & m0_stb_i;
  assign m1_ack_o = wb_ack_i & own1 & m1_stb_i;
  assign m1_err_o = (wb_err_i | to_hit) & own1 & m1_stb_i;
  assign m1_rty_o = wb_rty_i & own1 & m1_stb_i;

  // Read data is shared; held at zero only while reset is asserted.
  assign m0_dat_o = rst_n ? wb_dat_i : '0;
  assign m1_dat_o = rst_n ? wb_dat_i : '0;

  assign gnt_o    = {own1, own0};
  assign to_err_o = to_hit;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter with a short timeout (TO_CYCLES = 4).
module tb_wb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [31:0] m0_adr_i = 0, m0_dat_i = 0;
  logic [3:0]  m0_sel_i = 4'hf;
  logic [2:0]  m0_cti_i = 0;
  logic [1:0]  m0_bte_i = 0;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic [31:0] m0_dat_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [31:0] m1_adr_i = 0, m1_dat_i = 0;
  logic [3:0]  m1_sel_i = 4'hf;
  logic [2:0]  m1_cti_i = 0;
  logic [1:0]  m1_bte_i = 0;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic [31:0] m1_dat_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i, wb_err_i = 0, wb_rty_i = 0;
  logic [31:0] wb_dat_i = 32'hCAFE_F00D;
  logic [1:0]  gnt_o;
  logic        to_err_o;

  logic ack_en = 0, ack_force = 0;
  int   n_chk = 0, n_fail = 0;
  int   ack0_cnt = 0, ack1_cnt = 0;

  // Slave model: acks every strobe when enabled, or on demand.
  assign wb_ack_i = (ack_en & wb_cyc_o & wb_stb_o) | ack_force;

  always #5 clk = ~clk;

  wb_mem_arbiter #(.TO_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o), .m1_dat_o(m1_dat_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_dat_i(wb_dat_i),
    .gnt_o(gnt_o), .to_err_o(to_err_o)
  );

  always @(negedge clk) begin
    if (m0_ack_o) ack0_cnt++;
    if (m1_ack_o) ack1_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    m0_cti_i = 0; m1_cti_i = 0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_dat", m0_dat_o, 0);
    @(negedge clk); rst_n = 1;

    // m0 alone, 8-beat incrementing burst, slave acks every strobe
    ack_en = 1;
    nxt();
    m0_cyc_i = 1; m0_stb_i = 1; m0_cti_i = 3'b010; m0_adr_i = 32'h1000;
    #1 chk("b_req_gnt", gnt_o, 2'b00);
    ack0_cnt = 0; ack1_cnt = 0;
    for (int b = 0; b < 8; b++) begin
      nxt();
      m0_cti_i = (b == 7) ? 3'b111 : 3'b010;
      m0_adr_i = 32'h1000 + 32'(4 * b);
      #1;
      if (b == 0) chk("b_gnt", gnt_o, 2'b01);
      if (b == 5) chk("b_adr", wb_adr_o, 32'h1014);
      if (b == 7) chk("b_cti", wb_cti_o, 3'b111);
    end
    nxt(); idle_all();
    #1 chk("b_hold_gnt", gnt_o, 2'b01);
    nxt(); #1;
    chk("b_idle_gnt", gnt_o, 2'b00);
    chk("b_idle_adr", wb_adr_o, 0);
    chk("b_ack0", ack0_cnt, 8);
    chk("b_ack1", ack1_cnt, 0);
    chk("b_dat", m1_dat_o, 32'hCAFE_F00D);

    // fresh reset, then simultaneous contest
    nxt(); rst_n = 0; @(negedge clk); rst_n = 1;
    nxt();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h2000;
    #1 chk("c_req_gnt", gnt_o, 2'b00);
    nxt(); #1;
    chk("c_first", gnt_o, 2'b01);
    chk("c_m1_ack", m1_ack_o, 0);
    chk("c_m0_ack", m0_ack_o, 1);
    nxt(); m0_cyc_i = 0; m0_stb_i = 0;
    #1 chk("c_m0_drop", gnt_o, 2'b01);
    nxt(); #1 chk("c_handoff", gnt_o, 2'b10);
    nxt(); m1_cyc_i = 0; m1_stb_i = 0;
    nxt(); #1 chk("c_idle", gnt_o, 2'b00);
    nxt(); m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    nxt(); #1 chk("c_second", gnt_o, 2'b01);
    nxt(); idle_all();
    nxt(); nxt();

    // m1 owns, m0 requests mid-transfer: no preemption
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h3000;
    nxt(); #1 chk("p_gnt", gnt_o, 2'b10);
    for (int i = 1; i <= 3; i++) begin
      nxt();
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h4000;
      m1_adr_i = 32'h3000 + 32'(i * 4);
      #1;
      chk("p_gnt_hold", gnt_o, 2'b10);
      chk("p_adr", wb_adr_o, 32'h3000 + 32'(i * 4));
    end
    nxt(); m1_cyc_i = 0; m1_stb_i = 0;
    #1 chk("p_drop_gnt", gnt_o, 2'b10);
    nxt(); #1;
    chk("p_m0_gnt", gnt_o, 2'b01);
    chk("p_m0_adr", wb_adr_o, 32'h4000);
    nxt(); idle_all();
    nxt(); nxt();

    // timeout on an unanswered m1 single read
    ack_en = 0;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h5000;
    for (int i = 1; i <= 5; i++) begin
      nxt(); #1;
      if (i < 5) begin
        chk("t_err_lo", m1_err_o, 0);
        chk("t_stb_hi", wb_stb_o, 1);
      end else begin
        chk("t_err", m1_err_o, 1);
        chk("t_pulse", to_err_o, 1);
        chk("t_stb_lo", wb_stb_o, 0);
        chk("t_gnt", gnt_o, 2'b10);
        chk("t_m0_err", m0_err_o, 0);
      end
    end
    nxt(); #1;
    chk("t_after_err", m1_err_o, 0);
    chk("t_after_gnt", gnt_o, 2'b10);
    chk("t_after_stb", wb_stb_o, 1);
    nxt(); idle_all();
    nxt(); nxt();

    // ack arrives in the match cycle; then a real err is forwarded
    m1_cyc_i = 1; m1_stb_i = 1;
    for (int i = 1; i <= 5; i++) begin
      nxt();
      if (i == 5) ack_force = 1;
      #1;
    end
    chk("r_ack", m1_ack_o, 1);
    chk("r_err", m1_err_o, 0);
    chk("r_pulse", to_err_o, 0);
    nxt(); ack_force = 0; wb_err_i = 1;
    #1 chk("r_real_err", m1_err_o, 1);
    chk("r_real_pulse", to_err_o, 0);
    nxt(); wb_err_i = 0;
    #1 chk("r_err_gnt", gnt_o, 2'b10);
    chk("r_err_clear", m1_err_o, 0);
    nxt(); idle_all();
    nxt(); nxt();

    // reset mid-burst with m1 pending
    ack_en = 1;
    m0_cyc_i = 1; m0_stb_i = 1; m0_cti_i = 3'b010;
    nxt(); nxt();
    m1_cyc_i = 1; m1_stb_i = 1;
    #1 chk("x_pre_gnt", gnt_o, 2'b01);
    #1 rst_n = 0;
    #1;
    chk("x_cyc", wb_cyc_o, 0);
    chk("x_gnt", gnt_o, 2'b00);
    chk("x_ack", m0_ack_o, 0);
    @(negedge clk); rst_n = 1;
    #1 chk("x_no_early", gnt_o, 2'b00);
    nxt(); #1 chk("x_m0_busy", gnt_o, 2'b01);
    #1 rst_n = 0; m0_cyc_i = 0; m0_stb_i = 0;
    @(negedge clk); rst_n = 1;
    nxt(); #1 chk("x_m1_grant", gnt_o, 2'b10);
    nxt(); idle_all();
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/wb_mem_arbiter.md
WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 SHALL have parameter TO_CYCLES, default 255, range 1..255: cycles an owner's strobe may wait for a response before a synthetic error.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports m0_cyc_i / m1_cyc_i  in  1  bus request and cycle-valid; m0 is the instruction-line refill BIU, m1 is the ITLB walker.
REQ-005 SHALL have ports m0_stb_i / m1_stb_i, m0_we_i / m1_we_i  in  1  master strobe and write enable.
REQ-006 SHALL have ports m0_adr_i / m1_adr_i, m0_dat_i / m1_dat_i  in  32  master address and write data.
REQ-007 SHALL have ports m0_sel_i / m1_sel_i  in  4, m0_cti_i / m1_cti_i  in  3, m0_bte_i / m1_bte_i  in  2  master byte select, cycle type and burst type.
REQ-008 SHALL have ports m0_ack_o / m1_ack_o, m0_err_o / m1_err_o, m0_rty_o / m1_rty_o  out  1  per-master termination.
REQ-009 SHALL have ports m0_dat_o / m1_dat_o  out  32  read data to each master.
REQ-010 SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o  out  1; wb_adr_o, wb_dat_o  out  32; wb_sel_o  out  4; wb_cti_o  out  3; wb_bte_o  out  2  shared Wishbone master side.
REQ-011 SHALL have ports wb_ack_i, wb_err_i, wb_rty_i  in  1; wb_dat_i  in  32  shared Wishbone slave response.
REQ-012 SHALL have ports gnt_o  out  2  one-hot owner (bit0 = m0, bit1 = m1), 2'b00 when idle; to_err_o  out  1  one-cycle timeout pulse.

Function
REQ-013 SHALL implement states IDLE, OWN0 and OWN1, plus a 1-bit last_gnt register and an 8-bit timeout counter.
REQ-014 In IDLE, on a clock edge with exactly one mN_cyc_i high, the arbiter SHALL enter OWNN; the grant is visible on gnt_o and the bus one cycle after the request.
REQ-015 In IDLE with both cyc_i high, the arbiter SHALL grant the master that is not last_gnt (round-robin).
REQ-016 On entry to OWNN, last_gnt SHALL be set to N.
REQ-017 In OWNN, all wb_*_o outputs SHALL equal master N's inputs combinationally; wb_stb_o is additionally forced low in the timeout cycle.
REQ-018 In IDLE, all wb_*_o outputs SHALL be 0.
REQ-019 An owner SHALL never be preempted while its cyc_i is high, including across bursts with cti 3'b010 up to 3'b111.
REQ-020 In OWNN, on an edge where mN_cyc_i is low: if the other master's cyc_i is high, the arbiter SHALL move directly to the other OWN state; otherwise it SHALL move to IDLE.
REQ-021 mN_ack_o, mN_err_o and mN_rty_o SHALL equal wb_ack_i, wb_err_i and wb_rty_i ANDed with (owner == N) and mN_stb_i; a non-owner SHALL see 0.
REQ-022 mN_dat_o SHALL equal wb_dat_i for both masters.
REQ-023 The timeout counter SHALL clear on any state change, on any of wb_ack_i, wb_err_i or wb_rty_i, and whenever the owner's stb_i is low.
REQ-024 The timeout counter SHALL increment while the owner's stb_i is high and no response is present.
REQ-025 When the counter equals TO_CYCLES, the arbiter SHALL, that cycle: drive the owner's err_o to 1, force wb_stb_o to 0, pulse to_err_o, and clear the counter on the next edge.
REQ-026 After a timeout the grant SHALL be retained until the owner drops cyc_i.
REQ-027 A real wb_err_i or wb_rty_i SHALL be passed through per REQ-021 and SHALL NOT change state.
REQ-028 If a bus response arrives in the same cycle as the timeout match, the real response SHALL take precedence: no synthetic error, and the counter clears.
REQ-029 The arbiter SHALL never drive gnt_o = 2'b11.

Reset
REQ-030 While rst_n is low, regardless of the clock, the arbiter SHALL go to IDLE with last_gnt = 1 (so m0 wins the first contest), counter = 0, and all outputs 0.
REQ-031 A reset asserted mid-burst SHALL abort the transfer immediately (wb_cyc_o = 0), and no response SHALL be forwarded afterwards.
REQ-032 After rst_n rises, the first grant SHALL occur no earlier than the first rising edge of clk with rst_n high.

Verification
REQ-033 m0 requests alone, 8-beat read burst (cti 010 x7, then 111), slave acks every cycle -> gnt_o = 01 one cycle after request; 8 m0_ack_o pulses; m1_ack_o stays 0.
REQ-034 m0 and m1 raise cyc in the same cycle after reset -> m0 granted first; m1 is granted on the edge m0 drops cyc, with no IDLE cycle; a second simultaneous contest grants m0.
REQ-035 m1 owns the bus and m0 requests mid-transfer -> no preemption; wb_adr_o tracks m1_adr_i until m1_cyc_i falls.
REQ-036 TO_CYCLES = 4, the slave never acks an m1 single read -> m1_err_o = 1 and to_err_o = 1 in the 5th stb cycle; wb_stb_o = 0 that cycle; gnt_o stays 10.
REQ-037 The slave acks in exactly the cycle the counter hits TO_CYCLES -> m1_ack_o = 1, m1_err_o = 0, to_err_o = 0.
REQ-038 rst_n pulsed low mid-burst between clock edges -> all outputs 0 immediately; after release, a pending m1 request is granted only if m0 is idle.
